// File: rtl/board_pkg.sv
// Shared mode encoding and pattern helpers for the board-test LED controller.
package board_pkg;

  typedef enum logic [1:0] {
    MODE_MIRROR = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_t;

  localparam logic [3:0] WALK_INIT  = 4'b0001;
  localparam logic [3:0] BLINK_INIT = 4'b1111;
  localparam logic [3:0] COUNT_INIT = 4'b0000;

  // MIRROR has no stored pattern; it starts from the live debounced levels.
  function automatic logic [3:0] init_pattern(input mode_t m, input logic [3:0] mirror);
    case (m)
      MODE_WALK:  return WALK_INIT;
      MODE_BLINK: return BLINK_INIT;
      MODE_COUNT: return COUNT_INIT;
      default:    return mirror;
    endcase
  endfunction

  function automatic logic [3:0] step_pattern(input mode_t m, input logic [3:0] p,
                                              input logic down);
    case (m)
      MODE_WALK:  return down ? {p[0], p[3:1]} : {p[2:0], p[3]};
      MODE_BLINK: return ~p;
      MODE_COUNT: return down ? p - 4'd1 : p + 4'd1;
      default:    return p;
    endcase
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus stability counter for one switch; `clean` only
// follows `raw` after DEBOUNCE_COUNT consecutive mismatching cycles.
module switch_debouncer #(
  parameter int DEBOUNCE_COUNT = 50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic clean
);

  localparam int CW = $clog2(DEBOUNCE_COUNT);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_COUNT - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == clean) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        clean <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pattern_controller.sv
// Board-test controller: debounced switches select and pace one of four LED
// patterns; switch 0 cycles the mode, switch 1 toggles pause.
module led_pattern_controller
  import board_pkg::*;
#(
  parameter int DEBOUNCE_COUNT = 50000,
  parameter int TICK_COUNT     = 12500000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] switches,
  output logic [3:0] leds,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int PW = $clog2(TICK_COUNT);
  localparam logic [PW-1:0] TERM_NORM = PW'(TICK_COUNT - 1);
  localparam logic [PW-1:0] TERM_FAST = PW'(TICK_COUNT / 4 - 1);

  logic [3:0]    deb;
  logic [3:0]    deb_prev;
  mode_t         mode_q, mode_nxt;
  logic          paused, paused_nxt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic [3:0]    pattern, pattern_nxt;
  logic          tick_nxt;
  logic          press0, press1;
  logic [PW-1:0] term;
  logic          tick_due;

  for (genvar i = 0; i < 4; i++) begin : g_deb
    switch_debouncer #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_deb (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (switches[i]),
      .clean   (deb[i])
    );
  end

  assign press0 = deb[0] & ~deb_prev[0];
  assign press1 = deb[1] & ~deb_prev[1];

  // ">=" rather than "==" so a switch to fast speed mid-count wraps at once.
  assign term     = deb[3] ? TERM_FAST : TERM_NORM;
  assign tick_due = !paused && (pcnt >= term);

  always_comb begin
    mode_nxt    = mode_q;
    paused_nxt  = paused ^ press1;
    pcnt_nxt    = pcnt;
    pattern_nxt = pattern;
    tick_nxt    = 1'b0;
    if (!paused) pcnt_nxt = tick_due ? '0 : pcnt + 1'b1;
    if (press0) begin
      // Mode change beats a coincident tick: the step and its pulse are dropped.
      mode_nxt    = mode_t'(mode_q + 2'd1);
      pcnt_nxt    = '0;
      pattern_nxt = init_pattern(mode_nxt, deb);
    end else begin
      tick_nxt = tick_due;
      if (mode_q == MODE_MIRROR) pattern_nxt = deb;
      else if (tick_due) pattern_nxt = step_pattern(mode_q, pattern, deb[2]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      deb_prev <= '0;
      mode_q   <= MODE_MIRROR;
      paused   <= 1'b0;
      pcnt     <= '0;
      pattern  <= '0;
      tick     <= 1'b0;
    end else begin
      deb_prev <= deb;
      mode_q   <= mode_nxt;
      paused   <= paused_nxt;
      pcnt     <= pcnt_nxt;
      pattern  <= pattern_nxt;
      tick     <= tick_nxt;
    end
  end

  assign leds = pattern;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_controller.sv
// Directed bench for led_pattern_controller with DEBOUNCE_COUNT=4, TICK_COUNT=8;
// every expected value below is hand-derived from the debounce/prescaler timing.
module tb_led_pattern_controller;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] switches;
  logic [3:0] leds;
  logic [1:0] mode;
  logic       tick;

  int vectors = 0;
  int errors  = 0;

  led_pattern_controller #(.DEBOUNCE_COUNT(4), .TICK_COUNT(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .switches (switches),
    .leds     (leds),
    .mode     (mode),
    .tick     (tick)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic press_sw0();
    switches[0] = 1'b1;
    step(8);
    switches[0] = 1'b0;
    step(8);
  endtask

  logic [3:0] walk_exp [4];
  int         tick_seen;
  bit         found;

  initial begin
    walk_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset_n  = 1'b0;
    switches = 4'b0000;
    step(2);
    chk("reset_leds", leds, 4'b0000);
    chk("reset_mode", {2'b00, mode}, 4'd0);
    chk("reset_tick", {3'b000, tick}, 4'd0);

    // Mirror latency: level sampled on edge E shows on leds at E+6.
    reset_n  = 1'b1;
    switches = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("mirror_wait", leds, 4'b0000);
    end
    step(1);
    chk("mirror_value", leds, 4'b1010);
    chk("mirror_mode", {2'b00, mode}, 4'd0);

    // Bounce switch 1 with 3-cycle pulses, then hold it.
    switches = 4'b0000;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      switches = 4'b0010;
      step(3);
      switches = 4'b0000;
      step(3);
      chk("bounce_deb", leds, 4'b0000);
    end
    step(6);
    chk("bounce_settle", leds, 4'b0000);
    switches = 4'b0010;
    step(7);
    chk("bounce_hold", leds, 4'b0010);
    tick_seen = 0;
    for (int i = 0; i < 24; i++) begin
      step(1);
      if (tick) tick_seen++;
    end
    chk("single_pause_toggle", 4'(tick_seen), 4'd0);

    // WALK, direction up, normal then fast speed.
    switches = 4'b0000;
    do_reset();
    switches = 4'b0001;
    step(6);
    chk("walk_entry_wait", {2'b00, mode}, 4'd0);
    step(1);
    chk("walk_entry_mode", {2'b00, mode}, 4'd1);
    chk("walk_entry_leds", leds, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      step(7);
      chk("walk_no_tick", {3'b000, tick}, 4'd0);
      step(1);
      chk("walk_tick", {3'b000, tick}, 4'd1);
      chk("walk_leds", leds, walk_exp[i]);
    end
    switches = 4'b1001;
    step(10);
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found) begin
        if (tick) found = 1'b1;
        else step(1);
      end
    end
    chk("fast_tick_found", {3'b000, found}, 4'd1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("fast_gap", {3'b000, tick}, 4'd0);
      step(1);
      chk("fast_tick", {3'b000, tick}, 4'd1);
    end

    // COUNT down, then pause and resume.
    switches = 4'b0000;
    do_reset();
    switches = 4'b0100;
    step(8);
    chk("mirror_dir", leds, 4'b0100);
    press_sw0();
    press_sw0();
    chk("count_pre_mode", {2'b00, mode}, 4'd2);
    switches[0] = 1'b1;
    step(6);
    chk("count_entry_wait", {2'b00, mode}, 4'd2);
    step(1);
    chk("count_entry_mode", {2'b00, mode}, 4'd3);
    chk("count_entry_leds", leds, 4'b0000);
    step(7);
    chk("count_no_tick", {3'b000, tick}, 4'd0);
    step(1);
    chk("count_tick1", {3'b000, tick}, 4'd1);
    chk("count_down1", leds, 4'b1111);
    step(8);
    chk("count_down2", leds, 4'b1110);
    switches[1] = 1'b1;
    step(7);
    chk("pause_leds", leds, 4'b1110);
    chk("pause_tick", {3'b000, tick}, 4'd0);
    switches[1] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      chk("frozen_tick", {3'b000, tick}, 4'd0);
      chk("frozen_leds", leds, 4'b1110);
    end
    switches[1] = 1'b1;
    step(7);
    chk("resume_wait", {3'b000, tick}, 4'd0);
    step(1);
    chk("resume_tick", {3'b000, tick}, 4'd1);
    chk("resume_leds", leds, 4'b1101);
    step(8);
    chk("resume_leds2", leds, 4'b1100);

    // Press lands on a BLINK tick edge: mode change wins.
    switches = 4'b0000;
    do_reset();
    switches = 4'b0001;
    step(7);
    chk("blink_walk_mode", {2'b00, mode}, 4'd1);
    switches = 4'b0000;
    step(7);
    switches = 4'b0001;
    step(7);
    chk("blink_mode", {2'b00, mode}, 4'd2);
    chk("blink_init", leds, 4'b1111);
    switches = 4'b0000;
    step(8);
    chk("blink_tick", {3'b000, tick}, 4'd1);
    chk("blink_invert", leds, 4'b0000);
    step(1);
    switches = 4'b0001;
    step(7);
    chk("collide_mode", {2'b00, mode}, 4'd3);
    chk("collide_leds", leds, 4'b0000);

    // Reset dropped on the edge a WALK tick would land.
    switches = 4'b0000;
    do_reset();
    switches = 4'b0001;
    step(7);
    chk("rst_walk_mode", {2'b00, mode}, 4'd1);
    step(7);
    reset_n = 1'b0;
    step(1);
    chk("midrst_leds", leds, 4'b0000);
    chk("midrst_mode", {2'b00, mode}, 4'd0);
    chk("midrst_tick", {3'b000, tick}, 4'd0);
    reset_n = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_controller.md
# led_pattern_controller

Sequences the board's four user LEDs from the four user switches. Synchronises and debounces each switch, turns switch presses into control events, and drives the LEDs with one of four patterns stepped by an internal prescaler tick. Sits directly between the board switch pins and the LED pins as the top-level board-test controller.

## Interface
- DEBOUNCE_COUNT, 50000: consecutive stable cycles required before a debounced switch level changes; must be ≥2.
- TICK_COUNT, 12500000: clock cycles per pattern step at normal speed; must be ≥8 and a multiple of 4.
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- switches  in  4  raw asynchronous switch levels.
- leds  out  4  registered LED drive.
- mode  out  2  current pattern mode.
- tick  out  1  one-cycle pulse on each pattern step.

## Operation
- Synchroniser: two flops per switch, giving `sync[3:0]`.
- Debounce, per switch:
  - The counter clears whenever `sync` equals `deb`.
  - Otherwise the counter increments.
  - When the counter is DEBOUNCE_COUNT-1 and a mismatch is still present, `deb` takes `sync` and the counter clears.
- Events, taken from the previous `deb`:
  - `press0` = rising edge of `deb[0]`; advances mode 0→1→2→3→0.
  - `press1` = rising edge of `deb[1]`; toggles `paused`.
- Levels:
  - `deb[2]` sets direction: 0 = up/left, 1 = down/right.
  - `deb[3]` sets speed: 0 = normal, 1 = fast.
- Prescaler:
  - Terminal value is TICK_COUNT-1 at normal speed and TICK_COUNT/4-1 at fast speed.
  - When the count reaches or exceeds the terminal value and the block is not paused, the count wraps to 0 and `tick` pulses on the next cycle. This covers a speed change mid-count.
  - While paused, the count holds and no tick occurs.
- Modes:
  - MIRROR (0): `leds` <= `deb`. Ignores tick and pause.
  - WALK (1): one-hot pattern; each tick rotates left (bit0→bit3) or right, per direction.
  - BLINK (2): each tick inverts all bits.
  - COUNT (3): 4-bit counter; each tick adds 1 (up) or subtracts 1 (down); wraps 15↔0.
- On mode entry:
  - The pattern register loads WALK 0001, BLINK 1111 or COUNT 0000.
  - The prescaler clears.
  - `paused` is unchanged.
- Simultaneous events:
  - `press0` and tick in the same cycle: the mode change wins and the tick step is dropped.
  - `press0` and `press1` in the same cycle: both take effect.
- Reset state: all of these are 0: `leds`, `mode`, `tick`, `paused`, `deb`, both synchroniser stages, debounce counters, prescaler and pattern register.
- Reset asserted mid-operation returns every register to the reset state on that edge.

## Timing
- Mirror-mode latency: a level that is stable from edge E appears on `leds` at edge E+DEBOUNCE_COUNT+2. This is 2 sync edges, DEBOUNCE_COUNT-1 counting edges, and 1 output edge.
- A glitch shorter than DEBOUNCE_COUNT cycles after synchronisation never reaches `deb`.
- Mode change: `mode` updates one edge after `deb[0]` rises. The initialised pattern appears on `leds` on that same edge.
- Tick spacing: exactly TICK_COUNT cycles between ticks at normal speed and TICK_COUNT/4 at fast speed, while unpaused and with no mode change.
- `leds` changes on the edge on which `tick` is asserted.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `board_pkg`:
  - Mode constants MODE_MIRROR, MODE_WALK, MODE_BLINK, MODE_COUNT.
  - Pattern initial values WALK_INIT, BLINK_INIT, COUNT_INIT.
- Sub-module `switch_debouncer`:
  - Parameter DEBOUNCE_COUNT.
  - Ports: clock, reset_n, raw in, clean out.
  - Contains the synchroniser and counter for one switch.
  - Instantiated four times.
- The top level holds the event detect, pause/mode registers, prescaler and pattern FSM.

## Test plan
All scenarios use DEBOUNCE_COUNT=4 and TICK_COUNT=8.
- Reset, then hold `switches`=1010 stable → `leds`=0000 until DEBOUNCE_COUNT+2 edges, then 1010; `mode`=0 throughout.
- Bounce `switches[1]` with 3-cycle pulses, then hold it high → no `deb` change during the bouncing; exactly one pause toggle after the hold.
- One press of switch 0 → `mode`=1 and `leds`=0001. With direction up, ticks every 8 cycles give 0010, 0100, 1000, 0001. With `switches[3]` held high, ticks come every 2 cycles.
- Enter COUNT, set direction down → first tick gives `leds`=1111, then 1110. Press switch 1 → `leds` and `tick` frozen for 40 cycles; press again → stepping resumes 8 cycles later.
- Press switch 0 timed to land on the same edge as a tick while in BLINK → `mode`=3 and `leds`=0000, with no inverted step. Drop `reset_n` for one cycle mid-walk → all outputs 0 on the next edge, `mode`=0.
